// File: rtl/romix_blockmix_salsa.sv
// romix_blockmix_salsa: iterative scryptBlockMix core for r=1 with Salsa20/8.
// Takes B = B0||B1 (1024 bits) and produces Y0||Y1. One Salsa round
// (column or row) is evaluated per cycle to keep the combinational path short.

module romix_blockmix_salsa #(
   parameter int ROUNDS = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          blockmix_en,
   input  logic [1023:0] data_in,
   output logic [1023:0] data_out,
   output logic          blockmix_valid,
   output logic          busy
);

   localparam int CW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      MIX,
      ROUND,
      ADD,
      DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   round_cnt;
   logic            half;
   logic [1023:0]   b_reg;
   logic [511:0]    x_reg;
   logic [511:0]    work;
   logic [511:0]    feed_fwd;
   logic [511:0]    y0;

   logic [511:0]    mix_t;
   logic [511:0]    round_next;
   logic [511:0]    sum_words;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Salsa quarter-round: b, c, d, a updated in sequence with rotates 7/9/13/18
   function automatic logic [127:0] quarter(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
      logic [31:0] na, nb, nc, nd;
      nb = b ^ rotl(a + d, 7);
      nc = c ^ rotl(nb + a, 9);
      nd = d ^ rotl(nc + nb, 13);
      na = a ^ rotl(nd + nc, 18);
      return {na, nb, nc, nd};
   endfunction

   // One column round (row=0) or one row round (row=1) over the 16-word state
   function automatic logic [511:0] salsa_round(input logic [511:0] s, input logic row);
      logic [31:0]  x [16];
      logic [511:0] r;
      for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
      if (!row) begin
         {x[0],  x[4],  x[8],  x[12]} = quarter(x[0],  x[4],  x[8],  x[12]);
         {x[5],  x[9],  x[13], x[1]}  = quarter(x[5],  x[9],  x[13], x[1]);
         {x[10], x[14], x[2],  x[6]}  = quarter(x[10], x[14], x[2],  x[6]);
         {x[15], x[3],  x[7],  x[11]} = quarter(x[15], x[3],  x[7],  x[11]);
      end else begin
         {x[0],  x[1],  x[2],  x[3]}  = quarter(x[0],  x[1],  x[2],  x[3]);
         {x[5],  x[6],  x[7],  x[4]}  = quarter(x[5],  x[6],  x[7],  x[4]);
         {x[10], x[11], x[8],  x[9]}  = quarter(x[10], x[11], x[8],  x[9]);
         {x[15], x[12], x[13], x[14]} = quarter(x[15], x[12], x[13], x[14]);
      end
      r = '0;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
      return r;
   endfunction

   // Per-word addition mod 2^32 for the Salsa feed-forward
   function automatic logic [511:0] add_words(input logic [511:0] a, input logic [511:0] b);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
      return r;
   endfunction

   // Datapath: mix input, next round state and feed-forward sum
   always_comb begin
      mix_t      = x_reg ^ (half ? b_reg[1023:512] : b_reg[511:0]);
      round_next = salsa_round(work, round_cnt[0]);
      sum_words  = add_words(work, feed_fwd);
   end

   // Control FSM with registered outputs; the odd/even round parity comes from round_cnt[0]
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         round_cnt      <= '0;
         half           <= 1'b0;
         b_reg          <= '0;
         x_reg          <= '0;
         work           <= '0;
         feed_fwd       <= '0;
         y0             <= '0;
         data_out       <= '0;
         blockmix_valid <= 1'b0;
         busy           <= 1'b0;
      end else begin
         blockmix_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (blockmix_en) begin
                  b_reg <= data_in;
                  x_reg <= data_in[1023:512];
                  half  <= 1'b0;
                  busy  <= 1'b1;
                  state <= MIX;
               end
            end
            MIX: begin
               work      <= mix_t;
               feed_fwd  <= mix_t;
               round_cnt <= '0;
               state     <= ROUND;
            end
            ROUND: begin
               work <= round_next;
               if (round_cnt == CW'(ROUNDS - 1)) begin
                  state <= ADD;
               end else begin
                  round_cnt <= round_cnt + 1'b1;
               end
            end
            ADD: begin
               x_reg <= sum_words;
               if (!half) begin
                  y0    <= sum_words;
                  half  <= 1'b1;
                  state <= MIX;
               end else begin
                  data_out       <= {sum_words, y0};
                  blockmix_valid <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_romix_blockmix_salsa.sv
// tb_romix_blockmix_salsa: directed checks of the BlockMix core against the
// RFC 7914 scryptBlockMix / Salsa20/8 vectors plus hand-derived zero cases.

module tb_romix_blockmix_salsa;

   logic          clk = 1'b0;
   logic          reset;
   logic          blockmix_en;
   logic [1023:0] data_in;
   logic [1023:0] data_out;
   logic          blockmix_valid;
   logic          busy;

   int compared   = 0;
   int mismatched = 0;

   logic [511:0]  rfcB0, rfcB1, rfcY0, rfcY1, s8In, s8Out;
   logic [1023:0] rfcIn, rfcOut, dupIn, dupOut;

   romix_blockmix_salsa #(.ROUNDS(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .blockmix_en    (blockmix_en),
      .data_in        (data_in),
      .data_out       (data_out),
      .blockmix_valid (blockmix_valid),
      .busy           (busy)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // RFC vectors are written as byte strings; byte k lands at bits [8k+7:8k]
   function automatic logic [511:0] fromBytes(input logic [511:0] s);
      logic [511:0] r;
      r = '0;
      for (int k = 0; k < 64; k++) r[8*k +: 8] = s[511 - 8*k -: 8];
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      compared++;
      if (obs !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Launch one request and watch until the valid pulse (bounded at 60 cycles)
   task automatic applyStimulus(input logic [1023:0] blk, input int dropAt, input int scrambleAt,
                                output int lat, output int busyErr, output logic [1023:0] result);
      data_in     = blk;
      blockmix_en = 1'b1;
      @(posedge clk); #1;
      lat     = -1;
      busyErr = 0;
      result  = '0;
      for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
         if (cyc == dropAt) blockmix_en = 1'b0;
         if (cyc == scrambleAt) data_in = ~blk;
         if (!busy) busyErr++;
         if (blockmix_valid) begin
            lat    = cyc;
            result = data_out;
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      int lat, busyErr, v1, v2, holdErr, dblErr, cnt;
      logic [1023:0] res, res1, res2;
      logic prevValid;

      rfcB0  = fromBytes(512'hf7ce0b653d2d72a4108cf5abe912ffdd777616dbbb27a70e8204f3ae2d0f6fad89f68f4811d1e87bcc3bd7400a9ffd29094f0184639574f39ae5a1315217bcd7);
      rfcB1  = fromBytes(512'h894991447213bb226c25b54da86370fbcd984380374666bb8ffcb5bf40c254b067d27c51ce4ad5fed829c90b505a571b7f4d1cad6a523cda770e67bceaaf7e89);
      rfcY0  = fromBytes(512'ha41f859c6608cc993b81cacb020cef05044b2181a2fd337dfd7b1c6396682f29b4393168e3c9e6bcfe6bc5b7a06d96bae424cc102c91745c24ad673dc7618f81);
      rfcY1  = fromBytes(512'h20edc975323881a80540f64c162dcd3c21077cfe5f8d5fe2b1a4168f953678b77d3b3d803b60e4ab920996e59b4d53b65d2a225877d5edf5842cb9f14eefe425);
      s8In   = fromBytes(512'h7e879a214f3ec9867ca940e641718f26baee555b8c61c1b50df846116dcd3b1dee24f319df9b3d8514121e4b5ac5aa3276021d2909c74829edebc68db8b8c25e);
      s8Out  = rfcY0;
      rfcIn  = {rfcB1, rfcB0};
      rfcOut = {rfcY1, rfcY0};
      // B0 = B1: first Salsa input is zero (Y0 = 0), second is B1 itself
      dupIn  = {s8In, s8In};
      dupOut = {s8Out, 512'h0};

      reset       = 1'b1;
      blockmix_en = 1'b0;
      data_in     = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_lo", data_out[511:0], 512'h0);
      checkOutput("reset_out_hi", data_out[1023:512], 512'h0);
      checkOutput("reset_valid", 512'(blockmix_valid), 512'h0);
      checkOutput("reset_busy", 512'(busy), 512'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Zero block, single-cycle enable
      applyStimulus('0, 1, 0, lat, busyErr, res);
      checkOutput("zero_latency", 512'(lat), 512'd21);
      checkOutput("zero_busy_window", 512'(busyErr), 512'h0);
      checkOutput("zero_out_lo", res[511:0], 512'h0);
      checkOutput("zero_out_hi", res[1023:512], 512'h0);
      @(posedge clk); #1;
      checkOutput("zero_valid_width", 512'(blockmix_valid), 512'h0);
      checkOutput("zero_busy_after", 512'(busy), 512'h0);

      // RFC 7914 BlockMix vector, plus probe of the first Salsa call
      applyStimulus(rfcIn, 1, 0, lat, busyErr, res);
      checkOutput("rfc_latency", 512'(lat), 512'd21);
      checkOutput("rfc_y0", res[511:0], rfcY0);
      checkOutput("rfc_y1", res[1023:512], rfcY1);
      checkOutput("rfc_salsa8_probe", dut.y0, s8Out);
      @(posedge clk); #1;

      // Enable dropped at cycle 5, data_in scrambled while busy
      applyStimulus(rfcIn, 5, 3, lat, busyErr, res);
      checkOutput("drop_latency", 512'(lat), 512'd21);
      checkOutput("drop_y0", res[511:0], rfcY0);
      checkOutput("drop_y1", res[1023:512], rfcY1);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (busy || blockmix_valid) cnt++;
      end
      checkOutput("drop_no_recapture", 512'(cnt), 512'h0);

      // Back-to-back with enable held; second block applied on the first valid cycle
      data_in     = rfcIn;
      blockmix_en = 1'b1;
      @(posedge clk); #1;
      v1 = -1; v2 = -1; holdErr = 0; dblErr = 0; prevValid = 1'b0;
      res1 = '0; res2 = '0;
      for (int cyc = 1; cyc <= 70 && v2 < 0; cyc++) begin
         if (blockmix_valid && prevValid) dblErr++;
         if (v1 > 0 && !blockmix_valid && data_out !== res1) holdErr++;
         if (blockmix_valid) begin
            if (v1 < 0) begin
               v1      = cyc;
               res1    = data_out;
               data_in = dupIn;
            end else begin
               v2          = cyc;
               res2        = data_out;
               blockmix_en = 1'b0;
            end
         end
         prevValid = blockmix_valid;
         if (v2 < 0) begin
            @(posedge clk); #1;
         end
      end
      blockmix_en = 1'b0;
      checkOutput("b2b_first_valid", 512'(v1), 512'd21);
      checkOutput("b2b_second_valid", 512'(v2), 512'd43);
      checkOutput("b2b_first_y0", res1[511:0], rfcY0);
      checkOutput("b2b_first_y1", res1[1023:512], rfcY1);
      checkOutput("b2b_second_y0", res2[511:0], dupOut[511:0]);
      checkOutput("b2b_second_y1", res2[1023:512], dupOut[1023:512]);
      checkOutput("b2b_hold", 512'(holdErr), 512'h0);
      checkOutput("b2b_valid_double", 512'(dblErr), 512'h0);
      @(posedge clk); #1;
      checkOutput("b2b_valid_width", 512'(blockmix_valid), 512'h0);
      @(posedge clk); #1;
      checkOutput("b2b_idle_after", 512'(busy), 512'h0);

      // Reset at cycle 12 of a computation
      data_in     = rfcIn;
      blockmix_en = 1'b1;
      @(posedge clk); #1;
      blockmix_en = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midrst_out_lo", data_out[511:0], 512'h0);
      checkOutput("midrst_out_hi", data_out[1023:512], 512'h0);
      checkOutput("midrst_busy", 512'(busy), 512'h0);
      checkOutput("midrst_valid", 512'(blockmix_valid), 512'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (busy || blockmix_valid) cnt++;
      end
      checkOutput("midrst_quiet", 512'(cnt), 512'h0);
      applyStimulus(rfcIn, 1, 0, lat, busyErr, res);
      checkOutput("midrst_fresh_latency", 512'(lat), 512'd21);
      checkOutput("midrst_fresh_y0", res[511:0], rfcY0);
      checkOutput("midrst_fresh_y1", res[1023:512], rfcY1);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/romix_blockmix_salsa.md
Name: romix_blockmix_salsa

Overview:
- Iterative scryptBlockMix core (r=1, Salsa20/8) driven by the ROMix controller's blockmix_en / blockmix_valid handshake.
- Takes a 1024-bit block B = B0||B1 and returns Y0||Y1 per RFC 7914.
- Sits directly downstream of the ROMix control FSM. Its output feeds the ROMix XOR/mux datapath and scratchpad write port.
- Executes one Salsa round (column or row) per cycle to bound the combinational depth.

Parameters:
- ROUNDS, 8: Salsa rounds per core call; must be even and ≥2. Latency scales with it.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- blockmix_en  in  1  level request; sampled only in IDLE.
- data_in  in  1024  B; B0=[511:0], B1=[1023:512]; word i of each half at [32i+31:32i], little-endian words.
- data_out  out  1024  Y0=[511:0], Y1=[1023:512], same word layout as data_in.
- blockmix_valid  out  1  single-cycle completion pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high), any state: FSM→IDLE; round counter=0; half flag=0; work/feed-forward/Y0 registers=0; data_out=0; blockmix_valid=0; busy=0.
- States: IDLE, MIX, ROUND, ADD, DONE. Half flag h selects B0 (h=0) or B1 (h=1).
- IDLE: if blockmix_en=1, capture data_in into B register and set X=B1 (data_in[1023:512]); h=0; →MIX. Otherwise stay.
- MIX (1 cycle): T = X xor B_h, 32-bit wise. Load T into both the work register and the feed-forward register; round counter=0; →ROUND.
- ROUND (ROUNDS cycles): apply one Salsa round per cycle.
  - Even count: column round. Quarter-rounds on (0,4,8,12), (5,9,13,1), (10,14,2,6), (15,3,7,11).
  - Odd count: row round. Quarter-rounds on (0,1,2,3), (5,6,7,4), (10,11,8,9), (15,12,13,14).
  - Quarter-round rotates are 7, 9, 13, 18. Adds are mod 2^32.
  - After count=ROUNDS-1: →ADD.
- ADD (1 cycle): X = work + feed-forward, per word mod 2^32.
  - h=0: store X into Y0; h←1; →MIX.
  - h=1: data_out ← {X, Y0}; →DONE.
- DONE (1 cycle): blockmix_valid=1; →IDLE unconditionally.
- Latency: IDLE capture in cycle 0 puts blockmix_valid high in cycle 2·(ROUNDS+2)+1, which is 21 for ROUNDS=8.
- Back-to-back: if blockmix_en is still high in the following IDLE cycle, a new capture occurs. With en held high, the period is 22 cycles. data_in is sampled only on that IDLE cycle.
- data_out changes only at the ADD(h=1)→DONE edge. It is stable when blockmix_valid=1 and holds until the next completion or reset.
- blockmix_en deasserted mid-operation: ignored; the computation completes and blockmix_valid still pulses.
- blockmix_en and data_in changes while busy: ignored; the captured B is used.
- Reset asserted mid-operation: result discarded, no valid pulse. After release the block sits in IDLE.
- blockmix_valid is never high for two consecutive cycles.

Test Plan:
- All-zero data_in, en pulsed 1 cycle → blockmix_valid exactly 21 cycles after capture, lasting 1 cycle; data_out = 1024'h0; busy high cycles 1–20.
- RFC 7914 §9 scryptBlockMix r=1 input vector → data_out equals the §9 output vector. Also compare each Salsa call against the §8 Salsa20/8 vector via hierarchical probe.
- en held high with two different blocks (second changed on the valid cycle) → valids at cycles 21 and 43. The second result matches the reference model for the second block; data_out is unchanged between the two valids.
- Reset asserted at cycle 12 of a computation → valid never pulses; data_out=0, busy=0 immediately. A fresh request after release completes correctly.
- Random 1000 blocks vs. C reference model, random en gaps 0–5 cycles → every output matches. Each valid is one cycle wide with no pulse loss. data_in changes while busy have no effect.
- en dropped at cycle 5 → valid still at cycle 21 with the correct result; no new capture follows unless en is high in IDLE.
